// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module : mem_arb_pkg
// Brief  : Shared types and constants for the unified memory arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  // Byte-to-word address shift for 32-bit words
  localparam int WORD_OFF = 2;

endpackage

`default_nettype wire

// File: rtl/mem_arb_starve_ctr.sv
// ============================================================================
// Module : mem_arb_starve_ctr
// Brief  : Counts consecutive fetch losses; raises force_i at STARVE_MAX.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_req,
  input  logic i_gnt,
  output logic force_i
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (!i_req || i_gnt) begin
      r_cnt <= '0;
    end else if (r_cnt != C_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign force_i = i_req && (r_cnt == C_MAX);

endmodule

`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
// ============================================================================
// Module : unified_mem_arbiter
// Brief  : Shares one single-port sync RAM between fetch (I) and load/store
//          (D) ports, D-over-I priority. Optional starvation guard is enabled
//          with macro MEM_ARB_STARVE_GUARD_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_be,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [ADDR_W-3:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  owner_t r_owner;
  owner_t w_owner_nxt;
  logic   w_force_i;

  // Byte offset bits are the requester's concern
  logic w_unused_addr_lsbs;
  assign w_unused_addr_lsbs = ^{i_addr[WORD_OFF-1:0], d_addr[WORD_OFF-1:0]};

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk     (clk),
    .rstn    (rstn),
    .i_req   (i_req),
    .i_gnt   (i_gnt),
    .force_i (w_force_i)
  );
`else
  localparam int c_unused_starve_max = STARVE_MAX;
  assign w_force_i = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  always_comb begin
    i_gnt       = 1'b0;
    d_gnt       = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_be      = '0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_rvalid    = 1'b0;
    i_rdata     = '0;
    d_rvalid    = 1'b0;
    d_rdata     = '0;
    w_owner_nxt = OWN_NONE;

    if (rstn) begin
      d_gnt = d_req && !w_force_i;
      i_gnt = i_req && (!d_req || w_force_i);

      if (d_gnt) begin
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_be    = d_we ? d_be : '1;
        mem_addr  = d_addr[ADDR_W-1:WORD_OFF];
        mem_wdata = d_we ? d_wdata : '0;
        if (!d_we) begin
          w_owner_nxt = OWN_D;
        end
      end else if (i_gnt) begin
        mem_en      = 1'b1;
        mem_be      = '1;
        mem_addr    = i_addr[ADDR_W-1:WORD_OFF];
        w_owner_nxt = OWN_I;
      end

      // Response returning from last cycle's read; a read pending across reset is dropped
      case (r_owner)
        OWN_I: begin
          i_rvalid = 1'b1;
          i_rdata  = mem_rdata;
        end
        OWN_D: begin
          d_rvalid = 1'b1;
          d_rdata  = mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
// ============================================================================
// Module : tb_unified_mem_arbiter
// Brief  : Directed self-checking bench for unified_mem_arbiter with RAM model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_unified_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt, i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req, d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_be;
  logic              d_gnt, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en, mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-3:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk(clk), .rstn(rstn),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port synchronous RAM, word k initialised to 0x1000_0000 + k
  logic [DATA_W-1:0] ram [64];
  initial begin
    for (int k = 0; k < 64; k++) ram[k] = 32'h1000_0000 + k;
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[5:0]];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0;
    cyc(); cyc();
    #2;
    chk("rst_i_gnt", 64'(i_gnt), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    rstn = 1'b1;
    cyc();
    #2;
    chk("post_rst_rvalid", 64'({i_rvalid, d_rvalid}), 64'd0);

    // Lone fetch
    cyc();
    i_req = 1'b1; i_addr = 32'h10;
    #2;
    chk("t1_i_gnt", 64'(i_gnt), 64'd1);
    chk("t1_d_gnt", 64'(d_gnt), 64'd0);
    chk("t1_mem_addr", 64'(mem_addr), 64'h4);
    chk("t1_mem_be", 64'(mem_be), 64'hf);
    cyc();
    i_req = 1'b0;
    #2;
    chk("t1_i_rvalid", 64'(i_rvalid), 64'd1);
    chk("t1_i_rdata", 64'(i_rdata), 64'h1000_0004);
    chk("t1_idle_mem", 64'({mem_en, mem_we, mem_be, mem_addr, d_rvalid}), 64'd0);

    // Contention
    cyc();
    i_req = 1'b1; i_addr = 32'h30; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    #2;
    chk("t2_d_gnt", 64'(d_gnt), 64'd1);
    chk("t2_i_gnt", 64'(i_gnt), 64'd0);
    chk("t2_mem_addr", 64'(mem_addr), 64'h8);
    cyc();
    d_req = 1'b0;
    #2;
    chk("t2_i_gnt2", 64'(i_gnt), 64'd1);
    chk("t2_mem_addr2", 64'(mem_addr), 64'hc);
    chk("t2_d_rvalid", 64'({d_rvalid, i_rvalid}), 64'b10);
    chk("t2_d_rdata", 64'(d_rdata), 64'h1000_0008);
    chk("t2_i_rdata_zero", 64'(i_rdata), 64'd0);
    cyc();
    i_req = 1'b0;
    #2;
    chk("t2_i_rvalid", 64'({d_rvalid, i_rvalid}), 64'b01);
    chk("t2_i_rdata", 64'(i_rdata), 64'h1000_000c);

    // Store then fetch merged word
    cyc();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_be = 4'b0011; d_wdata = 32'hAABB_CCDD;
    #2;
    chk("t3_d_gnt", 64'(d_gnt), 64'd1);
    chk("t3_mem_we", 64'(mem_we), 64'd1);
    chk("t3_mem_addr", 64'(mem_addr), 64'h2);
    chk("t3_mem_be", 64'(mem_be), 64'h3);
    chk("t3_mem_wdata", 64'(mem_wdata), 64'hAABB_CCDD);
    cyc();
    d_req = 1'b0; d_we = 1'b0; i_req = 1'b1; i_addr = 32'h8;
    #2;
    chk("t3_no_d_rvalid", 64'(d_rvalid), 64'd0);
    chk("t3_i_gnt", 64'(i_gnt), 64'd1);
    cyc();
    i_req = 1'b0;
    #2;
    chk("t3_merged", 64'(i_rdata), 64'h1000_CCDD);
    chk("t3_no_d_rvalid2", 64'(d_rvalid), 64'd0);

    // Reset mid-read
    cyc();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
    #2;
    chk("t4_d_gnt", 64'(d_gnt), 64'd1);
    cyc();
    rstn = 1'b0; i_req = 1'b1;
    #2;
    chk("t4_gnts_in_rst", 64'({i_gnt, d_gnt, mem_en, mem_we}), 64'd0);
    chk("t4_d_rvalid_rst", 64'(d_rvalid), 64'd0);
    cyc();
    #2;
    chk("t4_d_rvalid_after", 64'({d_rvalid, i_rvalid, mem_en}), 64'd0);
    rstn = 1'b1; d_req = 1'b0; i_req = 1'b0;
    cyc();
    #2;
    chk("t4_d_rvalid_rel", 64'({d_rvalid, i_rvalid}), 64'd0);

    // Starvation: both held high
    cyc();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; i_req = 1'b1; i_addr = 32'h50;
    for (int k = 1; k <= 6; k++) begin
      #2;
      chk($sformatf("t5_gnt_c%0d", k), 64'({i_gnt, d_gnt}),
          (GUARD && k == 5) ? 64'b10 : 64'b01);
      cyc();
    end
    d_req = 1'b0; i_req = 1'b0;
    cyc();

    // Streaming alternate D/I reads on words 32..47
    for (int n = 0; n < 16; n++) begin
      d_req  = (n % 2 == 0);
      i_req  = (n % 2 == 1);
      d_addr = 32'((32 + n) * 4);
      i_addr = 32'((32 + n) * 4);
      #2;
      chk($sformatf("t6_en_c%0d", n), 64'(mem_en), 64'd1);
      chk($sformatf("t6_addr_c%0d", n), 64'(mem_addr), 64'(32 + n));
      if (n > 0) begin
        if ((n - 1) % 2 == 0)
          chk($sformatf("t6_resp_c%0d", n), 64'({d_rvalid, i_rvalid, d_rdata}),
              {30'd0, 2'b10, 32'h1000_0000 + 32'(32 + n - 1)});
        else
          chk($sformatf("t6_resp_c%0d", n), 64'({d_rvalid, i_rvalid, i_rdata}),
              {30'd0, 2'b01, 32'h1000_0000 + 32'(32 + n - 1)});
      end
      cyc();
    end
    d_req = 1'b0; i_req = 1'b0;
    #2;
    chk("t6_last_resp", 64'({d_rvalid, i_rvalid, i_rdata}),
        {30'd0, 2'b01, 32'h1000_002F});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
